// File: rtl/adc_pkg.sv
// adc_pkg
// Shared widths, the FSM state type and the 32-point sine table for the
// behavioural ADC front-end.
//   ADC_W       sample width (bits)
//   LUT_DEPTH   number of table entries
//   LUT_AW      table address width
//   SINE_LUT    round(128 + 127*sin(2*pi*k/32)), k = 0..31
package adc_pkg;

  localparam int ADC_W     = 8;
  localparam int LUT_DEPTH = 32;
  localparam int LUT_AW    = 5;

  typedef enum logic {
    IDLE,
    CONV
  } adc_state_t;

  localparam logic [ADC_W-1:0] SINE_LUT [0:LUT_DEPTH-1] = '{
    8'd128, 8'd153, 8'd177, 8'd199, 8'd218, 8'd234, 8'd245, 8'd253,
    8'd255, 8'd253, 8'd245, 8'd234, 8'd218, 8'd199, 8'd177, 8'd153,
    8'd128, 8'd103, 8'd79,  8'd57,  8'd38,  8'd22,  8'd11,  8'd3,
    8'd1,   8'd3,   8'd11,  8'd22,  8'd38,  8'd57,  8'd79,  8'd103
  };

endpackage

// File: rtl/adc_sine_rom.sv
// adc_sine_rom
// Combinational lookup into the package sine table.
//   addr  in   LUT_AW  table index
//   data  out  ADC_W   sample value at that index
module adc_sine_rom
  import adc_pkg::*;
(
  input  logic [LUT_AW-1:0] addr,
  output logic [ADC_W-1:0]  data
);

  assign data = SINE_LUT[addr];

endmodule

// File: rtl/adc.sv
// adc
// Behavioural 8-bit ADC front-end. Each rising edge of req (after
// synchronisation) starts a conversion; CONV_CYCLES clocks later the next
// sample of a stored sine wave appears on dat together with rdy=1.
//   clk  in   1      system clock, rising edge
//   rst  in   1      asynchronous reset, active-low
//   req  in   1      conversion request, asynchronous to clk
//   rdy  out  1      1 = dat holds a completed sample
//   dat  out  ADC_W  sample value, unsigned
module adc
  import adc_pkg::*;
#(
  parameter int CONV_CYCLES = 4,
  parameter int SYNC_STAGES = 2,
  parameter int STEP        = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  output logic             rdy,
  output logic [ADC_W-1:0] dat
);

  localparam logic [7:0]        CNT_LOAD = 8'(CONV_CYCLES - 1);
  localparam logic [LUT_AW-1:0] IDX_STEP = LUT_AW'(STEP % LUT_DEPTH);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   sync_prev;
  logic                   start;

  adc_state_t        state;
  logic [7:0]        cnt;
  logic [LUT_AW-1:0] idx;
  logic [ADC_W-1:0]  rom_data;

  // req is asynchronous, so it crosses into clk through a plain flop chain
  // before anything looks at it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], req};
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  // One-clock pulse on the synchronised rising edge, so a level-high req
  // starts exactly one conversion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_prev <= 1'b0;
    end else begin
      sync_prev <= sync_out;
    end
  end

  assign start = sync_out & ~sync_prev;

  adc_sine_rom u_rom (
    .addr (idx),
    .data (rom_data)
  );

  // Conversion FSM. Edges arriving while converting are dropped, not queued,
  // and idx only advances when a sample is actually delivered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      rdy   <= 1'b0;
      dat   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= CONV;
            rdy   <= 1'b0;
            cnt   <= CNT_LOAD;
          end
        end
        CONV: begin
          if (cnt == 8'd0) begin
            dat   <= rom_data;
            idx   <= idx + IDX_STEP;
            rdy   <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc.sv
// tb_adc
// Self-checking bench for adc. The reference is a sine table computed with
// real arithmetic plus a count of delivered samples; outputs are sampled on
// the falling clock edge.
module tb_adc;

  localparam int CONV_CYCLES = 4;
  localparam int SYNC_STAGES = 2;
  localparam int STEP        = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req = 1'b0;
  logic       rdy;
  logic [7:0] dat;

  int total = 0;
  int bad   = 0;

  int         modelLut [32];
  int         convCount;
  logic       expRdy;
  logic [7:0] expDat;
  logic [7:0] got;

  always #5 clk = ~clk;

  adc #(
    .CONV_CYCLES (CONV_CYCLES),
    .SYNC_STAGES (SYNC_STAGES),
    .STEP        (STEP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .req (req),
    .rdy (rdy),
    .dat (dat)
  );

  // Reference table straight from the sine formula.
  task automatic buildModel();
    real pi;
    pi = 3.14159265358979;
    for (int k = 0; k < 32; k++) begin
      modelLut[k] = $rtoi(128.0 + 127.0 * $sin(2.0 * pi * k / 32.0) + 0.5);
    end
  endtask

  function automatic logic [7:0] nextSample();
    return 8'(modelLut[(convCount * STEP) % 32]);
  endfunction

  task automatic checkOutput(input string tag, input logic er, input logic [7:0] ed);
    total++;
    assert (rdy === er) else begin
      bad++;
      $error("[TB] FAIL %s rdy: got %b want %b", tag, rdy, er);
    end
    total++;
    assert (dat === ed) else begin
      bad++;
      $error("[TB] FAIL %s dat: got %0d want %0d", tag, dat, ed);
    end
  endtask

  task automatic checkValue(input string tag, input logic [7:0] g, input logic [7:0] w);
    total++;
    assert (g === w) else begin
      bad++;
      $error("[TB] FAIL %s: got %0d want %0d", tag, g, w);
    end
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear at once.
  task automatic doReset();
    @(negedge clk);
    #2 rst = 1'b0;
    req = 1'b0;
    #1;
    convCount = 0;
    expRdy    = 1'b0;
    expDat    = 8'd0;
    checkOutput("rst_immediate", expRdy, expDat);
    repeat (2) begin
      @(negedge clk);
      checkOutput("rst_held", expRdy, expDat);
    end
    rst = 1'b1;
  endtask

  // One full request. k counts rising edges since req went high: the first
  // is the sampling edge E0, rdy falls at E0+SYNC_STAGES and the sample
  // lands CONV_CYCLES edges after that. With overlap set, req drops and
  // rises again so a second edge arrives while converting.
  task automatic applyStimulus(input int hold, input bit overlap, input int gap,
                               output logic [7:0] sample);
    int fallAt;
    int doneAt;
    fallAt = SYNC_STAGES + 1;
    doneAt = SYNC_STAGES + CONV_CYCLES + 1;
    req = 1'b1;
    for (int k = 1; k <= doneAt; k++) begin
      @(negedge clk);
      if (k < fallAt) begin
        checkOutput("pre_start", expRdy, expDat);
      end else if (k < doneAt) begin
        checkOutput("converting", 1'b0, expDat);
      end else begin
        expDat = nextSample();
        expRdy = 1'b1;
        convCount++;
        checkOutput("sample", expRdy, expDat);
      end
      if (overlap) begin
        if (k == 1) req = 1'b0;
        if (k == 2) req = 1'b1;
        if (k == 4) req = 1'b0;
      end else if (k == hold) begin
        req = 1'b0;
      end
    end
    req = 1'b0;
    sample = dat;
    repeat (gap) begin
      @(negedge clk);
      checkOutput("held", expRdy, expDat);
    end
  endtask

  initial begin
    logic [7:0] firstFive [5];
    firstFive = '{8'd128, 8'd153, 8'd177, 8'd199, 8'd218};
    buildModel();
    convCount = 0;
    expRdy    = 1'b0;
    expDat    = 8'd0;

    // Power-on reset for three clocks, then idle with req low.
    repeat (3) begin
      @(negedge clk);
      checkOutput("por", expRdy, expDat);
    end
    rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checkOutput("idle", expRdy, expDat);
    end

    // Single request with defaults, then four more in sequence.
    applyStimulus(2, 1'b0, 3, got);
    checkValue("seq0", got, firstFive[0]);
    for (int i = 1; i < 5; i++) begin
      applyStimulus(int'($urandom_range(1, 6)), 1'b0, int'($urandom_range(1, 4)), got);
      checkValue($sformatf("seq%0d", i), got, firstFive[i]);
    end

    // Second edge during a conversion must be ignored.
    doReset();
    applyStimulus(0, 1'b1, 10, got);
    checkValue("overlap_first", got, 8'd128);
    applyStimulus(2, 1'b0, 2, got);
    checkValue("overlap_next", got, 8'd153);

    // Reset two clocks after the conversion starts.
    req = 1'b1;
    for (int k = 1; k <= SYNC_STAGES + 3; k++) begin
      @(negedge clk);
      if (k <= SYNC_STAGES) checkOutput("abort_pre", expRdy, expDat);
      else checkOutput("abort_conv", 1'b0, expDat);
    end
    #2 rst = 1'b0;
    req = 1'b0;
    #1;
    convCount = 0;
    expRdy    = 1'b0;
    expDat    = 8'd0;
    checkOutput("abort_immediate", expRdy, expDat);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("abort_idle", expRdy, expDat);
    end
    applyStimulus(3, 1'b0, 2, got);
    checkValue("abort_next", got, 8'd128);

    // 33 randomised requests to cross the index wrap.
    doReset();
    for (int i = 1; i <= 33; i++) begin
      applyStimulus(int'($urandom_range(1, 6)), 1'b0, int'($urandom_range(1, 4)), got);
      if (i == 17) checkValue("wrap17", got, 8'd128);
      if (i == 25) checkValue("wrap25", got, 8'd1);
      if (i == 33) checkValue("wrap33", got, 8'd128);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
